// File: rtl/sordm5_keyboard_if.sv
// ---------------------------------------------------------------------------
// sordm5_keyboard_if
//   CPU-side read bus of the Sord M5 keyboard matrix (I/O ports 30h-37h).
//   cpu_addr : row select (3 bits) from the I/O decoder
//   cpu_rd   : one-cycle read strobe
//   cpu_dout : row data returned by the keyboard block, bit=1 means pressed
//   master   : the I/O decoder / CPU side
//   slave    : the keyboard block
// ---------------------------------------------------------------------------
interface sordm5_keyboard_if;
  logic [2:0] cpu_addr;
  logic       cpu_rd;
  logic [7:0] cpu_dout;

  modport master (output cpu_addr, output cpu_rd, input cpu_dout);
  modport slave  (input cpu_addr, input cpu_rd, output cpu_dout);
endinterface

// File: rtl/sordm5_keyboard.sv
// ---------------------------------------------------------------------------
// sordm5_keyboard
//   Turns hps_io ps2_key events into the Sord M5 8x8 keyboard matrix and
//   serves row reads to the Z80. F12 acts as the M5 RESET key (NMI request).
//   clk      : system clock (clk_sys)
//   reset_n  : asynchronous active-low reset
//   ps2_key  : [10] toggle strobe, [9] press, [8] E0 prefix, [7:0] set-2 code
//   kb_clear : synchronous pulse, releases every key
//   cpu      : read bus (cpu_addr, cpu_rd, cpu_dout), slave side
//   nmi_req  : high while F12 is held
//   busy     : high while an event is being decoded
// ---------------------------------------------------------------------------
module sordm5_keyboard #(
  parameter int ROWS         = 8,
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [10:0]             ps2_key,
  input  logic                    kb_clear,
  sordm5_keyboard_if.slave        cpu,
  output logic                    nmi_req,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, DECODE, UPDATE} state_t;

  state_t                 state, state_next;
  logic                   toggle_q;
  logic                   ps2_event;
  logic [9:0]             word;
  logic                   pending_valid;
  logic [9:0]             pending_word;
  logic                   lk_valid, lk_nmi, lk_press;
  logic [2:0]             lk_row, lk_col;
  logic [ROWS-1:0][7:0]   matrix, matrix_next;
  logic                   nmi_next;
  logic [7:0]             row_read;

  // Result encoding: {valid, nmi, row[2:0], col[2:0]}.
  function automatic logic [7:0] key_lookup(input logic [8:0] code);
    logic [7:0] r;
    r = 8'h00;
    case (code)
      9'h014, 9'h114: r = {2'b10, 3'd0, 3'd0};
      9'h011:         r = {2'b10, 3'd0, 3'd1};
      9'h012:         r = {2'b10, 3'd0, 3'd2};
      9'h059:         r = {2'b10, 3'd0, 3'd3};
      9'h029:         r = {2'b10, 3'd0, 3'd6};
      9'h05A, 9'h15A: r = {2'b10, 3'd0, 3'd7};
      9'h016: r = {2'b10, 3'd1, 3'd0};
      9'h01E: r = {2'b10, 3'd1, 3'd1};
      9'h026: r = {2'b10, 3'd1, 3'd2};
      9'h025: r = {2'b10, 3'd1, 3'd3};
      9'h02E: r = {2'b10, 3'd1, 3'd4};
      9'h036: r = {2'b10, 3'd1, 3'd5};
      9'h03D: r = {2'b10, 3'd1, 3'd6};
      9'h03E: r = {2'b10, 3'd1, 3'd7};
      9'h015: r = {2'b10, 3'd2, 3'd0};
      9'h01D: r = {2'b10, 3'd2, 3'd1};
      9'h024: r = {2'b10, 3'd2, 3'd2};
      9'h02D: r = {2'b10, 3'd2, 3'd3};
      9'h02C: r = {2'b10, 3'd2, 3'd4};
      9'h035: r = {2'b10, 3'd2, 3'd5};
      9'h03C: r = {2'b10, 3'd2, 3'd6};
      9'h043: r = {2'b10, 3'd2, 3'd7};
      9'h01C: r = {2'b10, 3'd3, 3'd0};
      9'h01B: r = {2'b10, 3'd3, 3'd1};
      9'h023: r = {2'b10, 3'd3, 3'd2};
      9'h02B: r = {2'b10, 3'd3, 3'd3};
      9'h034: r = {2'b10, 3'd3, 3'd4};
      9'h033: r = {2'b10, 3'd3, 3'd5};
      9'h03B: r = {2'b10, 3'd3, 3'd6};
      9'h042: r = {2'b10, 3'd3, 3'd7};
      9'h01A: r = {2'b10, 3'd4, 3'd0};
      9'h022: r = {2'b10, 3'd4, 3'd1};
      9'h021: r = {2'b10, 3'd4, 3'd2};
      9'h02A: r = {2'b10, 3'd4, 3'd3};
      9'h032: r = {2'b10, 3'd4, 3'd4};
      9'h031: r = {2'b10, 3'd4, 3'd5};
      9'h03A: r = {2'b10, 3'd4, 3'd6};
      9'h041: r = {2'b10, 3'd4, 3'd7};
      // Row 5/6 punctuation follows the JIS layout the M5 keytops mirror.
      9'h046: r = {2'b10, 3'd5, 3'd0};
      9'h045: r = {2'b10, 3'd5, 3'd1};
      9'h04E: r = {2'b10, 3'd5, 3'd2};
      9'h055: r = {2'b10, 3'd5, 3'd3};
      9'h049: r = {2'b10, 3'd5, 3'd4};
      9'h04A: r = {2'b10, 3'd5, 3'd5};
      9'h051: r = {2'b10, 3'd5, 3'd6};
      9'h06A: r = {2'b10, 3'd5, 3'd7};
      9'h044: r = {2'b10, 3'd6, 3'd0};
      9'h04D: r = {2'b10, 3'd6, 3'd1};
      9'h054: r = {2'b10, 3'd6, 3'd2};
      9'h05B: r = {2'b10, 3'd6, 3'd3};
      9'h04B: r = {2'b10, 3'd6, 3'd4};
      9'h04C: r = {2'b10, 3'd6, 3'd5};
      9'h052: r = {2'b10, 3'd6, 3'd6};
      9'h05D: r = {2'b10, 3'd6, 3'd7};
      // F12 is the RESET key: drives the NMI, owns no matrix bit.
      9'h007: r = {2'b01, 3'd0, 3'd0};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign ps2_event = ps2_key[10] ^ toggle_q;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ps2_event) state_next = DECODE;
      DECODE:  state_next = UPDATE;
      // An event arriving during UPDATE with nothing pending is taken
      // directly, so it cannot be stranded while the FSM sits in IDLE.
      UPDATE:  state_next = (pending_valid || ps2_event) ? DECODE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Event capture, one-entry pending slot, registered lookup, NMI, read port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q      <= ps2_key[10];
      word          <= '0;
      pending_valid <= 1'b0;
      pending_word  <= '0;
      lk_valid      <= 1'b0;
      lk_nmi        <= 1'b0;
      lk_press      <= 1'b0;
      lk_row        <= '0;
      lk_col        <= '0;
      nmi_req       <= 1'b0;
      cpu.cpu_dout  <= '0;
    end else begin
      toggle_q <= ps2_key[10];
      nmi_req  <= nmi_next;
      if (cpu.cpu_rd) cpu.cpu_dout <= row_read;
      case (state)
        IDLE: begin
          if (ps2_event) word <= ps2_key[9:0];
        end
        DECODE: begin
          {lk_valid, lk_nmi, lk_row, lk_col} <= key_lookup(word[8:0]);
          lk_press <= word[9];
          if (ps2_event) begin
            pending_valid <= 1'b1;
            pending_word  <= ps2_key[9:0];
          end
        end
        UPDATE: begin
          if (pending_valid) begin
            word          <= pending_word;
            pending_valid <= ps2_event;
            if (ps2_event) pending_word <= ps2_key[9:0];
          end else if (ps2_event) begin
            word <= ps2_key[9:0];
          end
        end
        default: ;
      endcase
    end
  end

  // kb_clear wins over a coincident UPDATE write.
  always_comb begin
    matrix_next = matrix;
    nmi_next    = nmi_req;
    if (kb_clear) begin
      matrix_next = '0;
      nmi_next    = 1'b0;
    end else if (state == UPDATE) begin
      if (lk_valid) matrix_next[lk_row][lk_col] = lk_press;
      if (lk_nmi)   nmi_next = lk_press;
    end
  end

  always_comb begin
    row_read = 8'h00;
    if (int'(cpu.cpu_addr) < ROWS && cpu.cpu_addr != 3'd7)
      row_read = matrix[cpu.cpu_addr];
  end

  generate
    if (CLR_ON_RESET) begin : g_matrix_clr
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) matrix <= '0;
        else          matrix <= matrix_next;
      end
    end else begin : g_matrix_keep
      always_ff @(posedge clk) begin
        matrix <= matrix_next;
      end
    end
  endgenerate

endmodule

// File: tb/tb_sordm5_keyboard.sv
// ---------------------------------------------------------------------------
// tb_sordm5_keyboard
//   Self-checking bench for sordm5_keyboard: a table of key events with the
//   expected row contents, plus hand-written multi-cycle corner cases.
//   Expected values go into a scoreboard queue and are popped on each check.
// ---------------------------------------------------------------------------
module tb_sordm5_keyboard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic        kb_clear;
  logic        nmi_req;
  logic        busy;

  sordm5_keyboard_if cpu_bus();

  sordm5_keyboard #(.ROWS(8), .CLR_ON_RESET(1'b1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_key  (ps2_key),
    .kb_clear (kb_clear),
    .cpu      (cpu_bus),
    .nmi_req  (nmi_req),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ext;
    logic [7:0] code;
    logic       press;
    logic [2:0] row;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs [22];
  logic [7:0] exp_q [$];
  int         compared = 0;
  int         failed   = 0;
  logic [7:0] rd;

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pushExpect(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual);
    logic [7:0] e;
    compared++;
    if (exp_q.size() == 0) begin
      failed++;
      $display("[TB] FAIL %s: got %02h, scoreboard empty", name, actual);
    end else begin
      e = exp_q.pop_front();
      if (actual !== e) begin
        failed++;
        $display("[TB] FAIL %s: got %02h expected %02h", name, actual, e);
      end
    end
  endtask

  // Called just after a negedge; flips the strobe so one event is seen.
  task automatic sendKey(input logic ext, input logic [7:0] code, input logic press);
    ps2_key = {~ps2_key[10], press, ext, code};
  endtask

  task automatic readRow(input logic [2:0] addr, output logic [7:0] data);
    cpu_bus.cpu_addr = addr;
    cpu_bus.cpu_rd   = 1'b1;
    @(negedge clk);
    cpu_bus.cpu_rd   = 1'b0;
    data = cpu_bus.cpu_dout;
  endtask

  task automatic pulseClear();
    kb_clear = 1'b1;
    @(negedge clk);
    kb_clear = 1'b0;
  endtask

  task automatic applyStimulus(input int idx);
    pushExpect(vecs[idx].exp);
    sendKey(vecs[idx].ext, vecs[idx].code, vecs[idx].press);
    waitCycles(3);
    readRow(vecs[idx].row, rd);
    checkOutput($sformatf("vec%0d_row%0d", idx, vecs[idx].row), rd);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //              ext   code   press row   exp
    vecs[0]  = '{1'b0, 8'h1B, 1'b1, 3'd3, 8'h03}; // S
    vecs[1]  = '{1'b0, 8'h1B, 1'b1, 3'd3, 8'h03}; // S repeat
    vecs[2]  = '{1'b0, 8'h1C, 1'b0, 3'd3, 8'h02}; // A release
    vecs[3]  = '{1'b0, 8'h1B, 1'b0, 3'd3, 8'h00}; // S release
    vecs[4]  = '{1'b0, 8'h23, 1'b0, 3'd3, 8'h00}; // D release, not held
    vecs[5]  = '{1'b0, 8'h16, 1'b1, 3'd1, 8'h01}; // 1
    vecs[6]  = '{1'b0, 8'h3E, 1'b1, 3'd1, 8'h81}; // 8
    vecs[7]  = '{1'b0, 8'h42, 1'b1, 3'd3, 8'h80}; // K
    vecs[8]  = '{1'b1, 8'h5A, 1'b1, 3'd0, 8'h80}; // E0 RETURN
    vecs[9]  = '{1'b1, 8'h75, 1'b1, 3'd0, 8'h80}; // E0 up arrow, invalid
    vecs[10] = '{1'b1, 8'h12, 1'b1, 3'd0, 8'h80}; // E0 12, invalid
    vecs[11] = '{1'b0, 8'h12, 1'b1, 3'd0, 8'h84}; // LSHIFT
    vecs[12] = '{1'b1, 8'h14, 1'b1, 3'd0, 8'h85}; // E0 CTRL
    vecs[13] = '{1'b0, 8'h11, 1'b1, 3'd0, 8'h87}; // FUNC
    vecs[14] = '{1'b0, 8'h1A, 1'b1, 3'd4, 8'h01}; // Z
    vecs[15] = '{1'b0, 8'h3A, 1'b1, 3'd4, 8'h41}; // M
    vecs[16] = '{1'b0, 8'h43, 1'b1, 3'd2, 8'h80}; // I
    vecs[17] = '{1'b0, 8'h4D, 1'b1, 3'd6, 8'h02}; // P
    vecs[18] = '{1'b0, 8'h4B, 1'b1, 3'd6, 8'h12}; // L
    vecs[19] = '{1'b0, 8'h46, 1'b1, 3'd5, 8'h01}; // 9
    vecs[20] = '{1'b1, 8'h5A, 1'b0, 3'd0, 8'h07}; // E0 RETURN release
    vecs[21] = '{1'b0, 8'h76, 1'b1, 3'd7, 8'h00}; // Esc, unmapped; row7

    // Reset with the strobe already high
    reset_n          = 1'b0;
    ps2_key          = 11'h400;
    kb_clear         = 1'b0;
    cpu_bus.cpu_addr = 3'd0;
    cpu_bus.cpu_rd   = 1'b0;
    waitCycles(3);
    pushExpect(8'h00); checkOutput("reset_dout", cpu_bus.cpu_dout);
    pushExpect(8'h00); checkOutput("reset_busy", {7'd0, busy});
    pushExpect(8'h00); checkOutput("reset_nmi", {7'd0, nmi_req});
    reset_n = 1'b1;
    waitCycles(3);
    pushExpect(8'h00); checkOutput("post_reset_busy", {7'd0, busy});
    for (int r = 0; r < 8; r++) begin
      pushExpect(8'h00);
      readRow(r[2:0], rd);
      checkOutput($sformatf("reset_row%0d", r), rd);
    end

    // Press A: latency and read-during-UPDATE
    sendKey(1'b0, 8'h1C, 1'b1);
    waitCycles(1);
    pushExpect(8'h01); checkOutput("a_busy", {7'd0, busy});
    pushExpect(8'h00); readRow(3'd3, rd); checkOutput("a_edge2", rd);
    pushExpect(8'h00); readRow(3'd3, rd); checkOutput("a_edge3_pre", rd);
    pushExpect(8'h01); readRow(3'd3, rd); checkOutput("a_after", rd);
    pushExpect(8'h00); checkOutput("a_idle", {7'd0, busy});

    for (int i = 0; i < 22; i++) applyStimulus(i);

    pulseClear();
    pushExpect(8'h00); readRow(3'd0, rd); checkOutput("clr_row0", rd);
    pushExpect(8'h00); readRow(3'd1, rd); checkOutput("clr_row1", rd);
    pushExpect(8'h00); readRow(3'd4, rd); checkOutput("clr_row4", rd);

    // Back-to-back: Q then W one cycle later
    sendKey(1'b0, 8'h15, 1'b1);
    waitCycles(1);
    sendKey(1'b0, 8'h1D, 1'b1);
    waitCycles(4);
    pushExpect(8'h03); readRow(3'd2, rd); checkOutput("b2b_row2", rd);
    pulseClear();

    // Four events on consecutive cycles: E is overwritten in pending by R
    sendKey(1'b0, 8'h15, 1'b1); waitCycles(1);
    sendKey(1'b0, 8'h1D, 1'b1); waitCycles(1);
    sendKey(1'b0, 8'h24, 1'b1); waitCycles(1);
    sendKey(1'b0, 8'h2D, 1'b1);
    waitCycles(8);
    pushExpect(8'h0B); readRow(3'd2, rd); checkOutput("lastwins_row2", rd);

    // kb_clear coincident with UPDATE of key 1, LSHIFT held before
    pushExpect(8'h04);
    sendKey(1'b0, 8'h12, 1'b1); waitCycles(3);
    readRow(3'd0, rd); checkOutput("lshift_row0", rd);
    sendKey(1'b0, 8'h16, 1'b1);
    waitCycles(2);
    pulseClear();
    waitCycles(1);
    pushExpect(8'h00); readRow(3'd1, rd); checkOutput("clrupd_row1", rd);
    pushExpect(8'h00); readRow(3'd0, rd); checkOutput("clrupd_row0", rd);
    pushExpect(8'h00); readRow(3'd2, rd); checkOutput("clrupd_row2", rd);

    // F12 = RESET key
    sendKey(1'b0, 8'h07, 1'b1);
    waitCycles(3);
    pushExpect(8'h01); checkOutput("f12_nmi_on", {7'd0, nmi_req});
    for (int r = 0; r < 8; r++) begin
      pushExpect(8'h00);
      readRow(r[2:0], rd);
      checkOutput($sformatf("f12_row%0d", r), rd);
    end
    sendKey(1'b0, 8'h07, 1'b0);
    waitCycles(3);
    pushExpect(8'h00); checkOutput("f12_nmi_off", {7'd0, nmi_req});

    // Async reset while key 5 is in DECODE
    sendKey(1'b0, 8'h2E, 1'b1);
    waitCycles(1);
    #1 reset_n = 1'b0;
    #1;
    pushExpect(8'h00); checkOutput("midreset_busy", {7'd0, busy});
    waitCycles(1);
    reset_n = 1'b1;
    waitCycles(4);
    pushExpect(8'h00); checkOutput("midreset_busy_after", {7'd0, busy});
    pushExpect(8'h00); readRow(3'd1, rd); checkOutput("midreset_row1", rd);

    if (exp_q.size() != 0) begin
      failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
